bin2ascii_seq: RTL and testbench

Parametrised sequential binary-to-ASCII decimal converter and the successor of the fixed 14-bit/4-digit BCD stage. It accepts an unsigned binary word over a valid/ready handshake and converts it with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It presents DIGITS ASCII characters to the downstream crossbar/UART formatter and holds them until the consumer accepts them. Added over the fixed stage: configurable width and digit count, overflow saturation, optional leading-zero blanking, and full backpressure.

---
 rtl/bin2ascii_seq.sv | 146 ++++++++++++++
 tb/tb_bin2ascii_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2ascii_seq.sv
// Sequential binary-to-ASCII decimal converter: an iterative double-dabble engine
// with a valid/ready handshake on both sides, overflow saturation and optional blanking.
module bin2ascii_seq #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8*DIGITS-1:0]   ascii_out,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  // Saturation forces all nines; blanking turns a zero digit into a space
  // only while every more significant digit is also zero.
  function automatic logic [8*DIGITS-1:0] to_ascii(input logic [BCD_W-1:0] bcd,
                                                   input logic             sat);
    logic [8*DIGITS-1:0] a;
    logic                lead;
    a    = '0;
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (bcd[4*k +: 4] != 4'd0) begin
        lead = 1'b0;
      end else begin
        lead = lead;
      end
      if (sat) begin
        a[8*k +: 8] = 8'h39;
      end else if ((BLANK_LZ != 0) && (k > 0) && lead) begin
        a[8*k +: 8] = 8'h20;
      end else begin
        a[8*k +: 8] = {4'h3, bcd[4*k +: 4]};
      end
    end
    return a;
  endfunction

  logic [1:0]          state_r;
  logic [BIN_W-1:0]    shift_r;
  logic [BCD_W-1:0]    bcd_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ovf_next_r;
  logic [8*DIGITS-1:0] ascii_r;
  logic                ovf_r;

  logic [BCD_W-1:0]    bcd_adj_s;
  logic [BCD_W-1:0]    bcd_next_s;
  logic                over_limit_s;
  logic                last_iter_s;

  // Add-3 correction on every nibble, then shift the next binary bit into the BCD word
  always_comb begin
    bcd_adj_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_r[4*k +: 4] >= 4'd5) begin
        bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4];
      end
    end
    bcd_next_s   = {bcd_adj_s[BCD_W-2:0], shift_r[BIN_W-1]};
    over_limit_s = (64'(bin_in) > LIMIT);
    last_iter_s  = (cnt_r == CNT_W'(BIN_W - 1));
  end

  // Handshake FSM and conversion datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bcd_r      <= '0;
      cnt_r      <= '0;
      ovf_next_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shift_r    <= bin_in;
            bcd_r      <= '0;
            cnt_r      <= '0;
            ovf_next_r <= over_limit_s;
            state_r    <= CONV;
          end
        end
        CONV: begin
          shift_r <= shift_r << 1;
          bcd_r   <= bcd_next_s;
          if (last_iter_s) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Result registers: loaded on the final iteration edge, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii_r <= {DIGITS{8'h30}};
      ovf_r   <= 1'b0;
    end else if ((state_r == CONV) && last_iter_s) begin
      ascii_r <= to_ascii(bcd_next_s, ovf_next_r);
      ovf_r   <= ovf_next_r;
    end
  end

  assign ascii_out = ascii_r;
  assign ovf       = ovf_r;
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

endmodule

// File: tb/tb_bin2ascii_seq.sv
// Scoreboard bench for bin2ascii_seq: four parameterisations, results checked
// against a divide/modulo decimal model.
module tb_bin2ascii_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // group 0/1: BIN_W=14 DIGITS=4, blanking off (a) and on (b), shared inputs
  logic [13:0] a_bin = '0;
  logic        a_vld = 1'b0, a_ordy = 1'b1;
  logic        a_irdy, a_oval, a_ov, b_irdy, b_oval, b_ov;
  logic [31:0] a_asc, b_asc;
  // group 2: BIN_W=20 DIGITS=6
  logic [19:0] c_bin = '0;
  logic        c_vld = 1'b0, c_ordy = 1'b1;
  logic        c_irdy, c_oval, c_ov;
  logic [47:0] c_asc;
  // group 3: BIN_W=8 DIGITS=3
  logic [7:0]  d_bin = '0;
  logic        d_vld = 1'b0, d_ordy = 1'b1;
  logic        d_irdy, d_oval, d_ov;
  logic [23:0] d_asc;

  bin2ascii_seq #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(0)) u_a (
    .clk(clk), .rst(rst), .bin_in(a_bin), .in_valid(a_vld), .in_ready(a_irdy),
    .ascii_out(a_asc), .ovf(a_ov), .out_valid(a_oval), .out_ready(a_ordy));
  bin2ascii_seq #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(1)) u_b (
    .clk(clk), .rst(rst), .bin_in(a_bin), .in_valid(a_vld), .in_ready(b_irdy),
    .ascii_out(b_asc), .ovf(b_ov), .out_valid(b_oval), .out_ready(a_ordy));
  bin2ascii_seq #(.BIN_W(20), .DIGITS(6), .BLANK_LZ(0)) u_c (
    .clk(clk), .rst(rst), .bin_in(c_bin), .in_valid(c_vld), .in_ready(c_irdy),
    .ascii_out(c_asc), .ovf(c_ov), .out_valid(c_oval), .out_ready(c_ordy));
  bin2ascii_seq #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(0)) u_d (
    .clk(clk), .rst(rst), .bin_in(d_bin), .in_valid(d_vld), .in_ready(d_irdy),
    .ascii_out(d_asc), .ovf(d_ov), .out_valid(d_oval), .out_ready(d_ordy));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [72:0] expq[4][$];
  int          accq[4][$];
  logic        pval[4];
  logic [71:0] pasc[4];
  logic        pov[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Decimal reference: digit k is (v / 10^k) % 10; leading zero means v < 10^k
  function automatic logic [72:0] model(input longint unsigned v, input int digits, input bit blank);
    longint unsigned p;
    logic [71:0]     a;
    logic            o;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    o = (v > p - 1);
    a = '0;
    p = 1;
    for (int k = 0; k < digits; k++) begin
      if (o) a[8*k +: 8] = 8'h39;
      else if (blank && k > 0 && v < p) a[8*k +: 8] = 8'h20;
      else a[8*k +: 8] = 8'h30 + 8'((v / p) % 10);
      p = p * 10;
    end
    return {o, a};
  endfunction

  task automatic mon(input int g, input int lat, input int digits, input bit blank,
                     input logic irdy, input logic ivld, input logic ordy, input logic oval,
                     input logic ov, input logic [63:0] bin, input logic [71:0] asc);
    logic [72:0] e;
    if (ivld && irdy) begin
      expq[g].push_back(model(bin, digits, blank));
      accq[g].push_back(cyc + 1);
    end
    if (oval && !pval[g]) begin
      if (accq[g].size() == 0) fail($sformatf("g%0d unexpected out_valid", g));
      else chk($sformatf("g%0d latency", g), 72'(cyc - accq[g].pop_front()), 72'(lat));
    end
    if (oval && pval[g]) begin
      chk($sformatf("g%0d ascii hold", g), asc, pasc[g]);
      chk($sformatf("g%0d ovf hold", g), 72'(ov), 72'(pov[g]));
      chk($sformatf("g%0d in_ready busy", g), 72'(irdy), 72'(0));
    end
    if (oval && ordy) begin
      if (expq[g].size() == 0) fail($sformatf("g%0d result without request", g));
      else begin
        e = expq[g].pop_front();
        chk($sformatf("g%0d ascii", g), asc, e[71:0]);
        chk($sformatf("g%0d ovf", g), 72'(ov), 72'(e[72]));
      end
    end
    pval[g] = oval;
    pasc[g] = asc;
    pov[g]  = ov;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, 14, 4, 1'b0, a_irdy, a_vld, a_ordy, a_oval, a_ov, 64'(a_bin), 72'(a_asc));
      mon(1, 14, 4, 1'b1, b_irdy, a_vld, a_ordy, b_oval, b_ov, 64'(a_bin), 72'(b_asc));
      mon(2, 20, 6, 1'b0, c_irdy, c_vld, c_ordy, c_oval, c_ov, 64'(c_bin), 72'(c_asc));
      mon(3, 8, 3, 1'b0, d_irdy, d_vld, d_ordy, d_oval, d_ov, 64'(d_bin), 72'(d_asc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    for (int g = 0; g < 4; g++) begin
      expq[g].delete();
      accq[g].delete();
      pval[g] = 1'b0;
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, " a in_ready"}, 72'(a_irdy), 72'(1));
    chk({tag, " a out_valid"}, 72'(a_oval), 72'(0));
    chk({tag, " a ovf"}, 72'(a_ov), 72'(0));
    chk({tag, " a ascii"}, 72'(a_asc), 72'(32'h30303030));
    chk({tag, " b ascii"}, 72'(b_asc), 72'(32'h30303030));
    chk({tag, " b in_ready"}, 72'(b_irdy), 72'(1));
    chk({tag, " c ascii"}, 72'(c_asc), 72'(48'h303030303030));
    chk({tag, " c out_valid"}, 72'(c_oval), 72'(0));
    chk({tag, " d ascii"}, 72'(d_asc), 72'(24'h303030));
    chk({tag, " d in_ready"}, 72'(d_irdy), 72'(1));
  endtask

  task automatic set_in(input int g, input logic [31:0] v, input logic vld);
    case (g)
      0: begin a_bin = v[13:0]; a_vld = vld; end
      2: begin c_bin = v[19:0]; c_vld = vld; end
      default: begin d_bin = v[7:0]; d_vld = vld; end
    endcase
  endtask

  task automatic set_ordy(input int g, input logic r);
    case (g)
      0: a_ordy = r;
      2: c_ordy = r;
      default: d_ordy = r;
    endcase
  endtask

  function automatic logic irdy_of(input int g);
    case (g)
      0: return a_irdy;
      2: return c_irdy;
      default: return d_irdy;
    endcase
  endfunction

  function automatic logic oval_of(input int g);
    case (g)
      0: return a_oval;
      2: return c_oval;
      default: return d_oval;
    endcase
  endfunction

  // One transaction: request, wait for result, stall the consumer, then release
  task automatic run(input int g, input logic [31:0] v, input int stall);
    int t;
    set_ordy(g, stall == 0);
    set_in(g, v, 1'b1);
    t = 0;
    while (!irdy_of(g) && t < 100) begin step(); t++; end
    if (t >= 100) fail($sformatf("g%0d timeout waiting in_ready", g));
    step();
    set_in(g, v, 1'b0);
    t = 0;
    while (!oval_of(g) && t < 100) begin step(); t++; end
    if (t >= 100) fail($sformatf("g%0d timeout waiting out_valid", g));
    repeat (stall) step();
    set_ordy(g, 1'b1);
    step();
    chk($sformatf("g%0d out_valid drop", g), 72'(oval_of(g)), 72'(0));
    chk($sformatf("g%0d in_ready back", g), 72'(irdy_of(g)), 72'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t;
    logic [31:0] dir_a[8];
    dir_a = '{32'd11, 32'd243, 32'd9999, 32'd10000, 32'd16383, 32'd0, 32'd1000, 32'd12000};
    clear_sb();
    repeat (3) step();
    check_rst("reset");
    rst = 1'b0;
    repeat (10) step();
    check_rst("idle hold");

    foreach (dir_a[i]) run(0, dir_a[i], 0);

    // backpressure: request held high with a changing value while busy
    a_ordy = 1'b0;
    a_bin  = 14'd1234;
    a_vld  = 1'b1;
    step();
    t = 0;
    while (!a_oval && t < 100) begin a_bin = 14'($urandom); step(); t++; end
    if (t >= 100) fail("backpressure timeout");
    repeat (6) begin a_bin = 14'($urandom); step(); end
    a_bin  = 14'd5678;
    a_ordy = 1'b1;
    step();
    chk("bp out_valid drop", 72'(a_oval), 72'(0));
    chk("bp in_ready rise", 72'(a_irdy), 72'(1));
    step();
    chk("bp held request accepted", 72'(a_irdy), 72'(0));
    a_vld = 1'b0;
    t = 0;
    while (!a_oval && t < 100) begin step(); t++; end
    if (t >= 100) fail("bp second result timeout");
    step();

    run(2, 32'd999999, 0);
    run(2, 32'd1048575, 2);
    run(2, 32'd0, 0);
    run(3, 32'd255, 0);
    run(3, 32'd7, 1);

    for (int i = 0; i < 30; i++) run(0, $urandom_range(0, 16383), $urandom_range(0, 3));
    for (int i = 0; i < 8; i++) run(2, $urandom_range(0, 1048575), $urandom_range(0, 2));
    for (int i = 0; i < 8; i++) run(3, $urandom_range(0, 255), $urandom_range(0, 2));

    // abort during iteration 7, asserting reset mid-cycle
    a_bin = 14'd5000;
    a_vld = 1'b1;
    step();
    a_vld = 1'b0;
    repeat (7) step();
    #2;
    rst = 1'b1;
    clear_sb();
    #1;
    check_rst("abort");
    step();
    step();
    rst = 1'b0;
    step();
    run(0, 32'd42, 0);

    repeat (3) step();
    for (int g = 0; g < 4; g++) chk($sformatf("g%0d scoreboard drained", g), 72'(expq[g].size()), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
